// File: rtl/note_sequencer_pkg.sv
// Shared types and defaults for the note record/playback controller.
package note_sequencer_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int NOTE_W_DEF = 32;
  localparam int SONG_MAX   = 64;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REC        = 3'd1,
    S_PLAY_WAIT  = 3'd2,
    S_PLAY_FETCH = 3'd3,
    S_PLAY_LATCH = 3'd4
  } seq_state_e;

  function automatic logic is_play_state(input seq_state_e s);
    return (s == S_PLAY_WAIT) || (s == S_PLAY_FETCH) || (s == S_PLAY_LATCH);
  endfunction

endpackage

// File: rtl/note_accumulator.sv
// Sticky-OR note register; wdata_o bypasses the current note so a beat's
// final cycle is captured with zero latency.
module note_accumulator
  import note_sequencer_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [NOTE_W-1:0] note_i,
  output logic [NOTE_W-1:0] wdata_o
);

  logic [NOTE_W-1:0] acc_q;
  logic [NOTE_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q | note_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign wdata_o = acc_q | note_i;

endmodule

// File: rtl/note_sequencer.sv
// Record/playback controller for the note RAM: owns all RAM controls,
// the beat pointer, song length and the played-note register.
//
// state        | meaning
// S_IDLE       | waiting for record/play command
// S_REC        | OR live notes over a beat, write one word per beat_tick
// S_PLAY_WAIT  | holding note_out, waiting for next beat_tick
// S_PLAY_FETCH | RAM samples ram_addr
// S_PLAY_LATCH | ram_q valid; latch into note_out, advance pointer
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NOTE_W = NOTE_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_record,
  input  logic              cmd_play,
  input  logic              cmd_stop,
  input  logic              loop_en,
  input  logic              beat_tick,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [NOTE_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [NOTE_W-1:0] ram_wdata,
  output logic [NOTE_W-1:0] note_out,
  output logic [ADDR_W:0]   song_len,
  output logic              is_record,
  output logic              is_play,
  output logic              done
);

  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] PTR_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] PTR_FULL = {1'b1, {ADDR_W{1'b0}}};

  seq_state_e        state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              end_q, end_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              wr_c;
  logic              done_c;
  logic              acc_clr;
  logic              acc_en;
  logic [NOTE_W-1:0] acc_wdata;
  logic [ADDR_W:0]   ptr_inc;

  assign ptr_inc = ptr_q + PTR_ONE;

  note_accumulator #(
    .NOTE_W (NOTE_W)
  ) u_acc (
    .clk     (clk),
    .resetn  (resetn),
    .clear_i (acc_clr),
    .en_i    (acc_en),
    .note_i  (note_in),
    .wdata_o (acc_wdata)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    end_d   = end_q;
    note_d  = note_q;
    wr_c    = 1'b0;
    done_c  = 1'b0;
    acc_clr = 1'b1;
    acc_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!cmd_stop) begin
          if (cmd_record) begin
            state_d = S_REC;
            ptr_d   = '0;
          end else if (cmd_play && (len_q != '0)) begin
            state_d = S_PLAY_WAIT;
            ptr_d   = '0;
            end_d   = 1'b0;
          end
        end
      end

      S_REC: begin
        // Stop wins over a coincident tick: the partial beat is dropped.
        if (cmd_stop) begin
          len_d   = ptr_q;
          state_d = S_IDLE;
        end else if (beat_tick) begin
          wr_c  = 1'b1;
          ptr_d = ptr_inc;
          if (ptr_q == PTR_LAST) begin
            len_d   = PTR_FULL;
            done_c  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          acc_clr = 1'b0;
          acc_en  = 1'b1;
        end
      end

      S_PLAY_WAIT: begin
        if (cmd_stop) begin
          note_d  = '0;
          state_d = S_IDLE;
        end else if (beat_tick) begin
          if (end_q && !loop_en) begin
            note_d  = '0;
            done_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            if (end_q) begin
              ptr_d = '0;
              end_d = 1'b0;
            end
            state_d = S_PLAY_FETCH;
          end
        end
      end

      S_PLAY_FETCH: begin
        if (cmd_stop) begin
          note_d  = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_PLAY_LATCH;
        end
      end

      S_PLAY_LATCH: begin
        if (cmd_stop) begin
          note_d  = '0;
          state_d = S_IDLE;
        end else begin
          note_d  = ram_q;
          ptr_d   = ptr_inc;
          end_d   = (ptr_inc == len_q);
          state_d = S_PLAY_WAIT;
        end
      end

      default: begin
        note_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      end_q   <= 1'b0;
      note_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      end_q   <= end_d;
      note_q  <= note_d;
    end
  end

  assign ram_addr  = ptr_q[ADDR_W-1:0];
  assign ram_wren  = wr_c;
  assign ram_wdata = wr_c ? acc_wdata : '0;
  assign note_out  = note_q;
  assign song_len  = len_q;
  assign is_record = (state_q == S_REC);
  assign is_play   = is_play_state(state_q);
  assign done      = done_c;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer with a behavioural 64x32 synchronous RAM.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_record, cmd_play, cmd_stop, loop_en, beat_tick;
  logic [31:0] note_in;
  logic [31:0] ram_q;
  logic [5:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [31:0] note_out;
  logic [6:0]  song_len;
  logic        is_record, is_play, done;

  note_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_record (cmd_record),
    .cmd_play   (cmd_play),
    .cmd_stop   (cmd_stop),
    .loop_en    (loop_en),
    .beat_tick  (beat_tick),
    .note_in    (note_in),
    .ram_q      (ram_q),
    .ram_addr   (ram_addr),
    .ram_wren   (ram_wren),
    .ram_wdata  (ram_wdata),
    .note_out   (note_out),
    .song_len   (song_len),
    .is_record  (is_record),
    .is_play    (is_play),
    .done       (done)
  );

  always #10 clk = ~clk;

  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  // Passive monitor: records writes and done pulses for the tasks to compare.
  logic [37:0] obs_wr[$];
  int          done_cnt = 0;
  logic [5:0]  done_addr = '0;
  logic        done_wr = 1'b0;
  always @(negedge clk) begin
    if (resetn && ram_wren) obs_wr.push_back({ram_addr, ram_wdata});
    if (resetn && done) begin
      done_cnt  <= done_cnt + 1;
      done_addr <= ram_addr;
      done_wr   <= ram_wren;
    end
  end

  int          n_chk = 0;
  int          n_fail = 0;
  logic [37:0] exp_wr[$];
  logic [31:0] exp_note[$];
  logic [31:0] song[$];

  task automatic drv(input logic rec, input logic ply, input logic stp,
                     input logic tck, input logic [31:0] nt);
    @(posedge clk); #1;
    cmd_record = rec; cmd_play = ply; cmd_stop = stp; beat_tick = tck; note_in = nt;
  endtask

  task automatic test_reset();
    resetn = 1'b0; loop_en = 1'b0;
    cmd_record = 0; cmd_play = 0; cmd_stop = 0; beat_tick = 0; note_in = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({ram_addr, ram_wren, ram_wdata, note_out, is_record, is_play, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%0h wren=%0b wdata=%0h note=%0h rec=%0b play=%0b done=%0b, expected all 0",
               ram_addr, ram_wren, ram_wdata, note_out, is_record, is_play, done);
    end
    n_chk++;
    if (song_len !== 7'd0) begin
      n_fail++; $display("FAIL reset_song_len: got %0d expected 0", song_len);
    end
    @(posedge clk); #1;
    resetn = 1'b1; note_in = '0;
  endtask

  task automatic test_play_empty();
    drv(0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if ({is_play, is_record} !== 2'b00) begin
      n_fail++; $display("FAIL play_empty: got play=%0b rec=%0b expected 0 0", is_play, is_record);
    end
  endtask

  task automatic test_priority();
    drv(1, 1, 1, 0, 0);
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if ({is_play, is_record} !== 2'b00) begin
      n_fail++; $display("FAIL prio_stop: got play=%0b rec=%0b expected 0 0", is_play, is_record);
    end
    drv(1, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if ({is_play, is_record} !== 2'b01) begin
      n_fail++; $display("FAIL prio_record: got play=%0b rec=%0b expected 0 1", is_play, is_record);
    end
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if ({song_len, is_record} !== {7'd0, 1'b0}) begin
      n_fail++; $display("FAIL prio_stop_len: got len=%0d rec=%0b expected 0 0", song_len, is_record);
    end
  endtask

  task automatic test_accumulate();
    logic [37:0] e, o;
    obs_wr.delete(); exp_wr.delete();
    drv(1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 32'h2);
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 32'h80);
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 0); exp_wr.push_back({6'd0, 32'h82});
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 0); exp_wr.push_back({6'd1, 32'h0});
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_chk++;
      if (obs_wr.size() == 0) begin
        n_fail++; $display("FAIL acc_write: got no write expected %0h", e);
      end else begin
        o = obs_wr.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL acc_write: got %0h expected %0h", o, e); end
      end
    end
    n_chk++;
    if (obs_wr.size() != 0) begin
      n_fail++; $display("FAIL acc_extra_write: got %0d extra expected 0", obs_wr.size());
    end
    n_chk++;
    if (song_len !== 7'd2) begin n_fail++; $display("FAIL acc_len: got %0d expected 2", song_len); end
  endtask

  task automatic test_record_basic();
    logic [37:0] e, o;
    logic [31:0] vals [3];
    int          done_base;
    vals[0] = 32'h1; vals[1] = 32'h40; vals[2] = 32'h1000;
    obs_wr.delete(); exp_wr.delete(); song.delete();
    done_base = done_cnt;
    drv(1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0);
      drv(0, 0, 0, 1, vals[i]);
      exp_wr.push_back({6'(i), vals[i]});
      song.push_back(vals[i]);
      drv(0, 0, 0, 0, 0);
    end
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_chk++;
      if (obs_wr.size() == 0) begin
        n_fail++; $display("FAIL rec_write: got no write expected %0h", e);
      end else begin
        o = obs_wr.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL rec_write: got %0h expected %0h", o, e); end
      end
    end
    n_chk++;
    if (obs_wr.size() != 0) begin
      n_fail++; $display("FAIL rec_extra_write: got %0d extra expected 0", obs_wr.size());
    end
    n_chk++;
    if (song_len !== 7'd3) begin n_fail++; $display("FAIL rec_len: got %0d expected 3", song_len); end
    n_chk++;
    if (done_cnt != done_base) begin
      n_fail++; $display("FAIL rec_no_done: got %0d pulses expected 0", done_cnt - done_base);
    end
  endtask

  task automatic test_play(input logic loop, input int nticks);
    logic [31:0] prev, e;
    int          done_base;
    loop_en = loop;
    done_base = done_cnt;
    exp_note.delete();
    prev = '0;
    drv(0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if (is_play !== 1'b1) begin n_fail++; $display("FAIL play_start: got %0b expected 1", is_play); end
    for (int i = 0; i < nticks; i++) begin
      exp_note.push_back(song[i % song.size()]);
      drv(0, 0, 0, 1, 0);
      drv(0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0);
      @(negedge clk);
      n_chk++;
      if (note_out !== prev) begin
        n_fail++; $display("FAIL play_hold[%0d]: got %0h expected %0h", i, note_out, prev);
      end
      drv(0, 0, 0, 0, 0);
      @(negedge clk);
      e = exp_note.pop_front();
      n_chk++;
      if (note_out !== e) begin
        n_fail++; $display("FAIL play_note[%0d]: got %0h expected %0h", i, note_out, e);
      end
      prev = e;
      drv(0, 0, 0, 0, 0);
    end
    if (!loop) drv(0, 0, 0, 1, 0);
    else       drv(0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if ({note_out, is_play} !== 33'd0) begin
      n_fail++; $display("FAIL play_end: got note=%0h play=%0b expected 0 0", note_out, is_play);
    end
    drv(0, 0, 0, 0, 0);
    n_chk++;
    if (done_cnt - done_base != (loop ? 0 : 1)) begin
      n_fail++; $display("FAIL play_done: got %0d pulses expected %0d", done_cnt - done_base, loop ? 0 : 1);
    end
  endtask

  task automatic test_record_full();
    logic [37:0] e, o;
    logic [31:0] v;
    int          done_base;
    obs_wr.delete(); exp_wr.delete();
    done_base = done_cnt;
    drv(1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      drv(0, 0, 0, 1, v);
      exp_wr.push_back({6'(i), v});
      drv(0, 0, 0, 0, 0);
    end
    drv(0, 0, 0, 1, 32'hDEAD);
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_chk++;
      if (obs_wr.size() == 0) begin
        n_fail++; $display("FAIL full_write: got no write expected %0h", e);
      end else begin
        o = obs_wr.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL full_write: got %0h expected %0h", o, e); end
      end
    end
    n_chk++;
    if (obs_wr.size() != 0) begin
      n_fail++; $display("FAIL full_extra_write: got %0d extra expected 0", obs_wr.size());
    end
    n_chk++;
    if (done_cnt - done_base != 1) begin
      n_fail++; $display("FAIL full_done_cnt: got %0d expected 1", done_cnt - done_base);
    end
    n_chk++;
    if ({done_addr, done_wr} !== {6'd63, 1'b1}) begin
      n_fail++; $display("FAIL full_done_at: got addr=%0d wren=%0b expected 63 1", done_addr, done_wr);
    end
    n_chk++;
    if ({song_len, is_record} !== {7'd64, 1'b0}) begin
      n_fail++; $display("FAIL full_len: got len=%0d rec=%0b expected 64 0", song_len, is_record);
    end
  endtask

  task automatic test_stop_tick();
    logic [37:0] o;
    obs_wr.delete();
    drv(1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 32'h5);
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 1, 1, 32'h9);
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if (obs_wr.size() != 1) begin
      n_fail++; $display("FAIL stoptick_count: got %0d writes expected 1", obs_wr.size());
    end else begin
      o = obs_wr.pop_front();
      n_chk++;
      if (o !== {6'd0, 32'h5}) begin n_fail++; $display("FAIL stoptick_write: got %0h expected %0h", o, {6'd0, 32'h5}); end
    end
    n_chk++;
    if (song_len !== 7'd1) begin n_fail++; $display("FAIL stoptick_len: got %0d expected 1", song_len); end
  endtask

  task automatic test_reset_mid_record();
    drv(1, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 32'h7);
    drv(0, 0, 0, 0, 32'h33);
    @(posedge clk); #1;
    resetn = 1'b0; note_in = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if ({ram_addr, ram_wren, ram_wdata, note_out, is_record, is_play, done} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got addr=%0h wren=%0b wdata=%0h note=%0h rec=%0b play=%0b done=%0b, expected all 0",
               ram_addr, ram_wren, ram_wdata, note_out, is_record, is_play, done);
    end
    n_chk++;
    if (song_len !== 7'd0) begin n_fail++; $display("FAIL midreset_len: got %0d expected 0", song_len); end
    @(posedge clk); #1;
    resetn = 1'b1; note_in = '0;
  endtask

  initial begin
    test_reset();
    test_play_empty();
    test_priority();
    test_accumulate();
    test_record_basic();
    test_play(1'b0, 3);
    test_play(1'b1, 4);
    test_record_full();
    test_stop_tick();
    test_reset_mid_record();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
